// File: rtl/cla_arb_pkg.sv
// rtl/cla_arb_pkg.sv - shared types and helpers for the round-robin CLA arbiter
package cla_arb_pkg;

    localparam int DATA_W   = 16;
    // Widest ID tag for the supported NUM_REQ range (2..8); the top narrows it.
    localparam int ID_MAX_W = 3;

    typedef struct packed {
        logic [DATA_W-1:0]   a;
        logic [DATA_W-1:0]   b;
        logic                cin;
        logic [ID_MAX_W-1:0] id;
    } op_t;

    typedef struct packed {
        logic [DATA_W-1:0]   sum;
        logic                cout;
        logic [ID_MAX_W-1:0] id;
    } rsp_t;

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/Hiera_CLA.sv
// rtl/Hiera_CLA.sv - 16-bit two-level carry-lookahead adder (4 x 4-bit groups)
module Hiera_CLA (
    input  logic [15:0] add_1,
    input  logic [15:0] add_2,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);

    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [15:0] w_c;
    logic [3:0]  w_bg;
    logic [3:0]  w_bp;
    logic [4:0]  w_gc;

    assign w_g = add_1 & add_2;
    assign w_p = add_1 ^ add_2;

    for (genvar k = 0; k < 4; k++) begin : g_blk
        localparam int B = 4 * k;
        assign w_c[B]   = w_gc[k];
        assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[k]);
        assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B]) | (&w_p[B+1:B] & w_gc[k]);
        assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1]) | (&w_p[B+2:B+1] & w_g[B])
                        | (&w_p[B+2:B] & w_gc[k]);
        assign w_bg[k]  = w_g[B+3] | (w_p[B+3] & w_g[B+2]) | (&w_p[B+3:B+2] & w_g[B+1])
                        | (&w_p[B+3:B+1] & w_g[B]);
        assign w_bp[k]  = &w_p[B+3:B];
    end

    // Second lookahead level: group carries computed in parallel, no ripple.
    assign w_gc[0] = c_in;
    assign w_gc[1] = w_bg[0] | (w_bp[0] & c_in);
    assign w_gc[2] = w_bg[1] | (w_bp[1] & w_bg[0]) | (&w_bp[1:0] & c_in);
    assign w_gc[3] = w_bg[2] | (w_bp[2] & w_bg[1]) | (&w_bp[2:1] & w_bg[0])
                   | (&w_bp[2:0] & c_in);
    assign w_gc[4] = w_bg[3] | (w_bp[3] & w_bg[2]) | (&w_bp[3:2] & w_bg[1])
                   | (&w_bp[3:1] & w_bg[0]) | (&w_bp[3:0] & c_in);

    assign sum   = w_p ^ w_c;
    assign c_out = w_gc[4];

endmodule

// File: rtl/rr_grant.sv
// rtl/rr_grant.sv - round-robin priority picker starting at i_ptr
module rr_grant #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_win_idx,
    output logic               o_any_grant
);

    logic [ID_W-1:0] w_pos [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_pos
        assign w_pos[k] = ID_W'((int'(i_ptr) + k) % NUM_REQ);
    end

    always_comb begin
        o_grant     = '0;
        o_win_idx   = '0;
        o_any_grant = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!o_any_grant && i_req[w_pos[k]]) begin
                o_any_grant         = 1'b1;
                o_win_idx           = w_pos[k];
                o_grant[w_pos[k]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cla_rr_arbiter.sv
// rtl/cla_rr_arbiter.sv - round-robin shared CLA adder, two-stage pipeline with tagged responses
module cla_rr_arbiter
    import cla_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]        req_cin,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_sum,
    output logic                      rsp_cout,
    output logic                      busy
);

    logic [ID_W-1:0]    r_rr_ptr;
    logic               r_s1_valid;
    logic               r_s2_valid;
    op_t                r_s1;
    rsp_t               r_s2;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_win;
    logic               w_any;
    logic               w_s2_adv;
    logic               w_s1_adv;
    logic               w_accept_en;
    logic               w_fire;
    logic [DATA_W-1:0]  w_sum;
    logic               w_cout;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_grant (
        .i_req       (req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_win_idx   (w_win),
        .o_any_grant (w_any)
    );

    Hiera_CLA u_cla (
        .add_1 (r_s1.a),
        .add_2 (r_s1.b),
        .c_in  (r_s1.cin),
        .sum   (w_sum),
        .c_out (w_cout)
    );

    // s1 can take a new operand whenever it is empty or draining this cycle.
    assign w_s2_adv    = !r_s2_valid || rsp_ready;
    assign w_s1_adv    = r_s1_valid && w_s2_adv;
    assign w_accept_en = !r_s1_valid || w_s2_adv;
    assign w_fire      = w_any && w_accept_en;
    assign req_ready   = w_accept_en ? w_grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s1       <= '0;
            r_s2       <= '0;
        end else begin
            if (w_fire) begin
                r_s1.a     <= req_a[int'(w_win)*DATA_W +: DATA_W];
                r_s1.b     <= req_b[int'(w_win)*DATA_W +: DATA_W];
                r_s1.cin   <= req_cin[w_win];
                r_s1.id    <= ID_MAX_W'(w_win);
                r_s1_valid <= 1'b1;
                r_rr_ptr   <= ID_W'(next_idx(int'(w_win), NUM_REQ));
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s1_adv) begin
                r_s2.sum   <= w_sum;
                r_s2.cout  <= w_cout;
                r_s2.id    <= r_s1.id;
                r_s2_valid <= 1'b1;
            end else if (w_s2_adv) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid = r_s2_valid;
    assign rsp_id    = ID_W'(r_s2.id);
    assign rsp_sum   = r_s2.sum;
    assign rsp_cout  = r_s2.cout;
    assign busy      = r_s1_valid || r_s2_valid;

endmodule

// File: tb/tb_cla_rr_arbiter.sv
// tb/tb_cla_rr_arbiter.sv - scoreboard bench for cla_rr_arbiter
module tb_cla_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*16-1:0] req_a;
    logic [NUM_REQ*16-1:0] req_b;
    logic [NUM_REQ-1:0]   req_cin;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [15:0]          rsp_sum;
    logic                 rsp_cout;
    logic                 busy;

    cla_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  id;
        logic [15:0] sum;
        logic        cout;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int b, input logic cin);
        req_a[i*16 +: 16] = 16'(a);
        req_b[i*16 +: 16] = 16'(b);
        req_cin[i]        = cin;
        req_valid[i]      = 1'b1;
    endtask

    task automatic push(input int id, input int sum, input int cout);
        exp_t e;
        e.id   = 3'(id);
        e.sum  = 16'(sum);
        e.cout = 1'(cout);
        sb.push_back(e);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
        tick();
    endtask

    // Monitor: pops on every accepted response and checks stall stability.
    bit          stalled = 1'b0;
    logic [1:0]  s_id;
    logic [15:0] s_sum;
    logic        s_cout;

    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", int'(rsp_valid), 1);
                check("stall_id",    int'(rsp_id),    int'(s_id));
                check("stall_sum",   int'(rsp_sum),   int'(s_sum));
                check("stall_cout",  int'(rsp_cout),  int'(s_cout));
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got id %0d sum %0d, expected no response", rsp_id, rsp_sum);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_id",   int'(rsp_id),   int'(e.id));
                    check("rsp_sum",  int'(rsp_sum),  int'(e.sum));
                    check("rsp_cout", int'(rsp_cout), int'(e.cout));
                end
            end
            stalled = rsp_valid && !rsp_ready;
            s_id    = rsp_id;
            s_sum   = rsp_sum;
            s_cout  = rsp_cout;
        end
    end

    logic [3:0] t4_ready [5] = '{4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000};

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_busy",      int'(busy),      0);
        check("reset_sum",       int'(rsp_sum),   0);
        check("reset_id",        int'(rsp_id),    0);
        check("reset_req_ready", int'(req_ready), 0);
        tick();
        rst       = 1'b0;
        rsp_ready = 1'b1;

        // Single op, latency of two cycles.
        set_req(0, 432, 765, 1'b1);
        push(0, 1198, 0);
        @(negedge clk);
        check("t1_grant", int'(req_ready), 1);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("t1_lat1_valid", int'(rsp_valid), 0);
        check("t1_lat1_busy",  int'(busy),      1);
        tick();
        @(negedge clk);
        check("t1_lat2_valid", int'(rsp_valid), 1);
        drain();

        // Carry boundary on requester 1, back to back.
        set_req(1, 65534, 1, 1'b0);
        push(1, 65535, 0);
        @(negedge clk);
        check("t2_grant_a", int'(req_ready), 2);
        tick();
        set_req(1, 65534, 1, 1'b1);
        push(1, 0, 1);
        @(negedge clk);
        check("t2_grant_b", int'(req_ready), 2);
        tick();
        req_valid = '0;
        drain();

        // Rotation with all requesters valid, starting from a fresh pointer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, i, 100, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("t3_grant_%0d", k), int'(req_ready), 1 << (k % 4));
            push(k % 4, 100 + (k % 4), 0);
            tick();
        end
        req_valid = '0;
        drain();

        // Downstream stall: two fires then backpressure to the requesters.
        rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, i, 100, 1'b0);
        push(1, 101, 0);
        push(2, 102, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("t4_ready_%0d", k), int'(req_ready), int'(t4_ready[k]));
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        drain();

        // Reset with both stages full: in-flight work is dropped.
        rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, i, 100, 1'b0);
        @(negedge clk);
        check("t5_grant_a", int'(req_ready), 8);
        tick();
        @(negedge clk);
        check("t5_grant_b", int'(req_ready), 1);
        tick();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        set_req(1, 1000, 2000, 1'b0);
        set_req(3, 7, 7, 1'b0);
        @(negedge clk);
        check("t5_rst_valid", int'(rsp_valid), 0);
        check("t5_rst_busy",  int'(busy),      0);
        check("t5_rst_sum",   int'(rsp_sum),   0);
        check("t5_first_grant", int'(req_ready), 2);
        push(1, 3000, 0);
        tick();
        req_valid = '0;
        drain();

        // Single requester held valid: granted every cycle, full-range wrap.
        set_req(2, 65535, 65535, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("t6_grant_%0d", k), int'(req_ready), 4);
            if (k >= 2) check($sformatf("t6_tput_%0d", k), int'(rsp_valid), 1);
            push(2, 65535, 1);
            tick();
        end
        req_valid = '0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cla_rr_arbiter.md
Name: cla_rr_arbiter

Overview:
- Shares one 16-bit Hiera_CLA adder among NUM_REQ requesters, e.g. FIR tap-sum lanes or coefficient-update paths.
- Round-robin arbitration with a valid/ready handshake per requester.
- Two-stage pipeline: operand register feeding the adder, then a result register.
- Downstream backpressure on the response port; responses are tagged with the requester ID.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of requester ID tag.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*16  packed addend 1; slice i belongs to requester i.
- req_b  in  NUM_REQ*16  packed addend 2.
- req_cin  in  NUM_REQ  per-requester carry-in.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accepts result.
- rsp_id  out  ID_W  requester index of the result.
- rsp_sum  out  16  a+b+cin, mod 2^16.
- rsp_cout  out  1  carry-out of the 16-bit add.
- busy  out  1  s1_valid | s2_valid.

Behaviour:
- Reset, synchronous: rr_ptr=0, s1_valid=0, s2_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0. rsp_valid=0 and busy=0 in the cycle after rst is sampled high.
- Reset mid-operation discards any in-flight operands. Requesters must re-present them.
- Stage advance:
  - s2_adv = !s2_valid | rsp_ready.
  - s1_adv = s1_valid & s2_adv.
  - accept_en = !s1_valid | s2_adv.
- Arbitration, combinational:
  - Winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[winner] = accept_en. All other bits are 0.
  - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- Handshake fires when req_valid[i] & req_ready[i]. On fire:
  - s1 registers {a, b, cin, id=i} and sets s1_valid=1.
  - rr_ptr <= (i+1) mod NUM_REQ.
- With no fire: rr_ptr holds. s1_valid <= 0 if s1_adv, otherwise s1 holds.
- Adder: Hiera_CLA fed from the s1 register (add_1, add_2, c_in). It is purely combinational in the s1->s2 path.
- On s1_adv: s2 registers {sum, c_out, id} and sets s2_valid=1.
- When s2_adv & !s1_adv: s2_valid <= 0.
- rsp_valid = s2_valid. rsp_* outputs come straight from the s2 registers.
- Latency: fire in cycle N gives rsp_valid in cycle N+2 when unstalled.
- Throughput: 1 op/cycle when rsp_ready is held high.
- Stall:
  - rsp_valid=1 & rsp_ready=0 freezes s2. s1 holds if valid.
  - req_ready=0 everywhere only while s1 is full and stalled, so at most 2 results are in flight.
  - rsp_* must stay stable while rsp_valid=1 & rsp_ready=0.
- Simultaneous events:
  - rsp_ready and a new fire in the same cycle: s2<-s1 and s1<-new, no bubble.
  - All requesters valid: grants rotate 0,1,2,3,0,...
  - A single requester held valid is granted every cycle.
- Wrap-around: rr_ptr wraps from NUM_REQ-1 to 0. Sum wraps modulo 2^16, with overflow reported only via rsp_cout.
- Ordering: responses leave in grant order.

Decomposition:
- Package cla_arb_pkg:
  - DATA_W=16 localparam.
  - typedef op_t {a, b, cin, id}.
  - typedef rsp_t {sum, cout, id}.
- Sub-module rr_grant: NUM_REQ-wide round-robin priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, winner index, any_grant.
- Hiera_CLA is instantiated unchanged as the adder.

Test Plan:
- Reset then req0 a=432 b=765 cin=1, rsp_ready=1 -> two cycles after fire: rsp_sum=1198, rsp_cout=0, rsp_id=0.
- req1 a=65534 b=1 cin=0, then req1 a=65534 b=1 cin=1 -> rsp_sum=65535, cout=0; then rsp_sum=0, cout=1.
- All 4 requesters valid continuously, each with a=i b=100 -> grants cycle 0,1,2,3,0. rsp_id sequence matches, sums 100..103.
- rsp_ready=0 for 5 cycles with all requesters valid -> exactly 2 fires, then req_ready=0. rsp_* stable. On rsp_ready=1, results drain in order with no loss or duplication.
- Assert rst for 1 cycle with s1 and s2 full -> next cycle rsp_valid=0, busy=0, rr_ptr=0. First grant after reset goes to the lowest valid index.
- req2 only, a=65535 b=65535 cin=1 back-to-back -> one result per cycle, rsp_sum=65535, rsp_cout=1, rsp_id=2.
